// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr, adef} with redirect flush.
// Optional same-cycle empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module inst_fetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [PC_W-1:0]            if_pc,
    input  logic [INSTR_W-1:0]         if_instr,
    input  logic                       if_adef,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [PC_W-1:0]            id_pc,
    output logic [INSTR_W-1:0]         id_instr,
    output logic                       id_adef,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               adef;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            full;
    logic            empty;
    logic            byp;
    logic            push;
    logic            pop;
    entry_t          head;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign if_ready = !full;

    // Bypass hands an incoming word straight to decode while the queue is empty.
`ifdef IFQ_BYPASS_EN
    assign byp = empty & if_valid & !flush;
`else
    assign byp = 1'b0;
`endif

    assign push = if_valid & if_ready & !flush & !(byp & id_ready);
    assign pop  = !empty & id_ready & !flush;

    always_comb begin
        head = mem[rd_ptr];
        if (byp) begin
            head = '{pc: if_pc, instr: if_instr, adef: if_adef};
        end
    end

    assign id_valid = !empty | byp;
    assign id_pc    = head.pc;
    assign id_instr = head.instr;
    assign id_adef  = head.adef;

    // Entries are cleared on reset so the head never drives X into decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: if_pc, instr: if_instr, adef: if_adef};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule
